toggle_lock_monitor: RTL and testbench

- Downstream consumer of the single-bit toggling output of the two-state Moore FSM (A→B→A…).
- Checks that the stream alternates every cycle, declares lock after a run of good toggles, and counts toggles while locked.
- Raises a sticky fault when toggles go missing. Used as a liveness/health checker on the toggle stage.

---
 rtl/toggle_mon_pkg.sv | 19 +
 rtl/toggle_detect.sv | 21 ++
 rtl/toggle_lock_monitor.sv | 136 +++++++++++++
 tb/tb_toggle_lock_monitor.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_mon_pkg.sv
// Shared types and constants for the toggle lock monitor.
package toggle_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACQUIRE = 2'b01,
        LOCKED  = 2'b10,
        FAULT   = 2'b11
    } state_t;

    localparam logic IRQ_CAUSE_LOCK  = 1'b0;
    localparam logic IRQ_CAUSE_FAULT = 1'b1;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/toggle_detect.sv
// Remembers the previous sample of the toggle stream and flags a change.
module toggle_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic toggle_in,
    output logic tog
);

    logic prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= 1'b0;
        end else begin
            prev <= toggle_in;
        end
    end

    assign tog = (toggle_in != prev);

endmodule

// File: rtl/toggle_lock_monitor.sv
// Liveness checker for an alternating toggle stream: acquire, lock, count, fault.
// Optional interrupt outputs are enabled by defining TOGGLE_MON_IRQ_EN.
module toggle_lock_monitor
    import toggle_mon_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int MAX_MISS   = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             toggle_in,
    input  logic             clear,
    output state_t           state,
    output logic             locked,
    output logic             fault,
    output logic [CNT_W-1:0] toggle_count
`ifdef TOGGLE_MON_IRQ_EN
    ,
    output logic             irq,
    output logic             irq_cause
`endif
);

    localparam int RUN_W  = cnt_width(LOCK_COUNT);
    localparam int MISS_W = cnt_width(MAX_MISS);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MAX_MISS - 1);

    state_t            next_state;
    logic              tog;
    logic [RUN_W-1:0]  run_cnt;
    logic [MISS_W-1:0] miss_cnt;

    toggle_detect u_detect (
        .clk       (clk),
        .reset_n   (reset_n),
        .toggle_in (toggle_in),
        .tog       (tog)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (en) next_state = ACQUIRE;
            end
            ACQUIRE: begin
                if (!en)                           next_state = IDLE;
                else if (tog && run_cnt == RUN_LAST) next_state = LOCKED;
            end
            LOCKED: begin
                if (!en)                             next_state = IDLE;
                else if (!tog && miss_cnt == MISS_LAST) next_state = FAULT;
            end
            FAULT: begin
                if (clear) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        locked = (state == LOCKED);
        fault  = (state == FAULT);
    end

    // Counters only move while enabled; leaving LOCKED or FAULT keeps the count visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_cnt      <= '0;
            miss_cnt     <= '0;
            toggle_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        run_cnt      <= '0;
                        miss_cnt     <= '0;
                        toggle_count <= '0;
                    end
                end
                ACQUIRE: begin
                    if (en) begin
                        if (!tog) begin
                            run_cnt <= '0;
                        end else if (run_cnt != RUN_LAST) begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (en) begin
                        if (tog) begin
                            miss_cnt <= '0;
                            if (toggle_count != '1) toggle_count <= toggle_count + 1'b1;
                        end else if (miss_cnt != MISS_LAST) begin
                            miss_cnt <= miss_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TOGGLE_MON_IRQ_EN
    logic lock_entry;
    logic fault_entry;

    assign lock_entry  = (next_state == LOCKED) && (state != LOCKED);
    assign fault_entry = (next_state == FAULT)  && (state != FAULT);

    // Pulse lines up with the state register so irq and the new state appear together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq       <= 1'b0;
            irq_cause <= 1'b0;
        end else begin
            irq <= lock_entry || fault_entry;
            if (lock_entry)       irq_cause <= IRQ_CAUSE_LOCK;
            else if (fault_entry) irq_cause <= IRQ_CAUSE_FAULT;
        end
    end
`endif

endmodule

// File: tb/tb_toggle_lock_monitor.sv
// Bench for toggle_lock_monitor: fixed vector table, corner sequences, random run vs model.
module tb_toggle_lock_monitor;
    import toggle_mon_pkg::*;

    localparam int LOCK_COUNT = 4;
    localparam int MAX_MISS   = 2;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset_n;
    logic             en;
    logic             toggle_in;
    logic             clear;
    state_t           state;
    logic             locked;
    logic             fault;
    logic [CNT_W-1:0] toggle_count;
`ifdef TOGGLE_MON_IRQ_EN
    logic             irq;
    logic             irq_cause;
`endif

    toggle_lock_monitor #(
        .LOCK_COUNT (LOCK_COUNT),
        .MAX_MISS   (MAX_MISS),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .toggle_in    (toggle_in),
        .clear        (clear),
        .state        (state),
        .locked       (locked),
        .fault        (fault),
        .toggle_count (toggle_count)
`ifdef TOGGLE_MON_IRQ_EN
        ,
        .irq          (irq),
        .irq_cause    (irq_cause)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=idle 1=acquire 2=locked 3=fault
    int m_mode, m_run, m_miss, m_count, m_irq, m_cause;
    bit m_prev;
    bit tin;

    typedef struct {
        bit en;
        bit tin;
        bit clr;
        int st;
        int cnt;
        bit irq;
        bit cause;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; m_run = 0; m_miss = 0; m_count = 0;
        m_irq = 0; m_cause = 0; m_prev = 1'b0;
    endfunction

    function automatic void model_step(input bit e, input bit t, input bit c);
        bit changed;
        int nxt;
        changed = (t != m_prev);
        m_prev  = t;
        nxt     = m_mode;
        case (m_mode)
            0: if (e) begin nxt = 1; m_run = 0; m_miss = 0; m_count = 0; end
            1: begin
                if (!e) nxt = 0;
                else if (!changed) m_run = 0;
                else if (m_run + 1 >= LOCK_COUNT) nxt = 2;
                else m_run++;
            end
            2: begin
                if (!e) nxt = 0;
                else if (changed) begin
                    m_miss  = 0;
                    m_count = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
                end
                else if (m_miss + 1 >= MAX_MISS) nxt = 3;
                else m_miss++;
            end
            default: if (c) nxt = 0;
        endcase
        m_irq = (nxt != m_mode && nxt >= 2) ? 1 : 0;
        if (m_irq != 0) m_cause = (nxt == 3) ? 1 : 0;
        m_mode = nxt;
    endfunction

    task automatic check_output(input string tag);
        check({tag, ".state"},  32'(state),        32'(m_mode));
        check({tag, ".locked"}, 32'(locked),       32'(m_mode == 2));
        check({tag, ".fault"},  32'(fault),        32'(m_mode == 3));
        check({tag, ".count"},  32'(toggle_count), 32'(m_count));
`ifdef TOGGLE_MON_IRQ_EN
        check({tag, ".irq"},    32'(irq),          32'(m_irq));
        check({tag, ".cause"},  32'(irq_cause),    32'(m_cause));
`endif
    endtask

    task automatic apply_stimulus(input bit e, input bit t, input bit c, input string tag);
        en = e; toggle_in = t; clear = c;
        @(posedge clk);
        model_step(e, t, c);
        #1;
        check_output(tag);
    endtask

    task automatic run_toggles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tin = ~tin;
            apply_stimulus(1'b1, tin, 1'b0, tag);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; en = 1'b0; toggle_in = 1'b0; clear = 1'b0; tin = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        vecs[0]  = '{1, 0, 0, 1, 0, 0, 0};
        vecs[1]  = '{1, 1, 0, 1, 0, 0, 0};
        vecs[2]  = '{1, 0, 0, 1, 0, 0, 0};
        vecs[3]  = '{1, 1, 0, 1, 0, 0, 0};
        vecs[4]  = '{1, 0, 0, 2, 0, 1, 0};
        vecs[5]  = '{1, 1, 0, 2, 1, 0, 0};
        vecs[6]  = '{1, 0, 0, 2, 2, 0, 0};
        vecs[7]  = '{1, 1, 0, 2, 3, 0, 0};
        vecs[8]  = '{1, 1, 0, 2, 3, 0, 0};
        vecs[9]  = '{1, 0, 0, 2, 4, 0, 0};
        vecs[10] = '{1, 0, 0, 2, 4, 0, 0};
        vecs[11] = '{1, 0, 0, 3, 4, 1, 1};
        vecs[12] = '{0, 1, 0, 3, 4, 0, 1};
        vecs[13] = '{0, 0, 1, 0, 4, 0, 1};
        vecs[14] = '{0, 0, 0, 0, 4, 0, 1};

        reset_n = 1'b0; en = 1'b0; toggle_in = 1'b0; clear = 1'b0; tin = 1'b0;
        model_reset();
        #3;
        check("reset.state", 32'(state), 32'(IDLE));
        check("reset.count", 32'(toggle_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, "idle");

        // Clean lock, single miss, double miss, sticky fault, clear.
        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vecs[i].en, vecs[i].tin, vecs[i].clr, $sformatf("vec%0d", i));
            check($sformatf("vec%0d.st", i),  32'(state),        32'(vecs[i].st));
            check($sformatf("vec%0d.cnt", i), 32'(toggle_count), 32'(vecs[i].cnt));
`ifdef TOGGLE_MON_IRQ_EN
            check($sformatf("vec%0d.irq", i),   32'(irq),       32'(vecs[i].irq));
            check($sformatf("vec%0d.cause", i), 32'(irq_cause), 32'(vecs[i].cause));
`endif
        end
        tin = vecs[14].tin;

        // Broken acquire: three toggles, one miss, then four toggles needed.
        apply_stimulus(1'b1, tin, 1'b0, "brk.start");
        check("brk.acq", 32'(state), 32'(ACQUIRE));
        check("brk.cnt0", 32'(toggle_count), 0);
        run_toggles(3, "brk.tog3");
        apply_stimulus(1'b1, tin, 1'b0, "brk.miss");
        check("brk.after_miss", 32'(state), 32'(ACQUIRE));
        run_toggles(3, "brk.retog3");
        check("brk.not_yet", 32'(locked), 0);
        run_toggles(1, "brk.retog4");
        check("brk.locked", 32'(locked), 1);

        // Count to five, then reset mid-cycle with no clock edge in between.
        run_toggles(5, "cnt5");
        check("cnt5.value", 32'(toggle_count), 5);
        #2;
        reset_n = 1'b0;
        #1;
        check("async.state",  32'(state), 32'(IDLE));
        check("async.locked", 32'(locked), 0);
        check("async.count",  32'(toggle_count), 0);
        en = 1'b0; toggle_in = 1'b0; tin = 1'b0;
        model_reset();
        #1;
        reset_n = 1'b1;

        // Saturation, then en drop holds the count, then re-enable clears it.
        apply_stimulus(1'b1, tin, 1'b0, "sat.start");
        run_toggles(LOCK_COUNT, "sat.lock");
        check("sat.locked", 32'(locked), 1);
        run_toggles(20, "sat.run");
        check("sat.value", 32'(toggle_count), 15);
        tin = ~tin;
        apply_stimulus(1'b0, tin, 1'b0, "sat.endrop");
        check("sat.idle", 32'(state), 32'(IDLE));
        check("sat.hold", 32'(toggle_count), 15);
        apply_stimulus(1'b1, tin, 1'b0, "sat.reen");
        check("sat.acq", 32'(state), 32'(ACQUIRE));
        check("sat.clr", 32'(toggle_count), 0);

        // Random traffic against the model, with an occasional reset.
        for (int i = 0; i < 800; i++) begin
            bit e, c;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                check_output("rnd.reset");
            end
            e = ($urandom_range(0, 24) != 0);
            c = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) < 8) tin = ~tin;
            apply_stimulus(e, tin, c, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
